// File: rtl/camera_pattern_tx_pkg.sv
// Shared definitions for the OV7670-style test pattern transmitter:
// RGB565 colours, PATTERN encodings and FSM state encoding.
package camera_pattern_tx_pkg;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  typedef enum logic [1:0] {
    PatBars    = 2'd0,
    PatRed     = 2'd1,
    PatGreen   = 2'd2,
    PatChecker = 2'd3
  } pattern_e;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StVsync  = 3'd1,
    StVback  = 3'd2,
    StActive = 3'd3,
    StHblank = 3'd4,
    StVfront = 3'd5
  } state_e;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = RGB_WHITE;
      3'd1:    c = RGB_YELLOW;
      3'd2:    c = RGB_CYAN;
      3'd3:    c = RGB_GREEN;
      3'd4:    c = RGB_MAGENTA;
      3'd5:    c = RGB_RED;
      3'd6:    c = RGB_BLUE;
      default: c = RGB_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pattern_gen.sv
// Combinational mapping of (pattern, x, y) to one RGB565 pixel value.
module pattern_gen
  import camera_pattern_tx_pkg::*;
#(
  parameter int unsigned WIDTH = 176,
  parameter int unsigned XW    = 8,
  parameter int unsigned YW    = 8
) (
  input  pattern_e        i_pattern,
  input  logic [XW-1:0]   i_x,
  input  logic [YW-1:0]   i_y,
  output logic [15:0]     o_rgb
);

  logic [2:0] w_bar;
  logic       w_chk;

  assign w_bar = 3'((32'(i_x) * 32'd8) / WIDTH);
  // Square size is 16 pixels: colour flips with bit 4 of x and of y.
  assign w_chk = 1'((32'(i_x) ^ 32'(i_y)) >> 4);

  always_comb begin
    o_rgb = RGB_BLACK;
    case (i_pattern)
      PatBars:    o_rgb = bar_color(w_bar);
      PatRed:     o_rgb = RGB_RED;
      PatGreen:   o_rgb = RGB_GREEN;
      PatChecker: o_rgb = w_chk ? RGB_WHITE : RGB_BLACK;
      default:    o_rgb = RGB_BLACK;
    endcase
  end

endmodule

// File: rtl/camera_pattern_tx.sv
// OV7670 output-side emulator: PCLK/VSYNC/HREF/DATA frames of RGB565 test patterns.
// All outputs change on the CLOCK edge that drives PCLK low.
module camera_pattern_tx
  import camera_pattern_tx_pkg::*;
#(
  parameter int unsigned WIDTH         = 176,
  parameter int unsigned HEIGHT        = 144,
  parameter int unsigned H_BLANK       = 32,
  parameter int unsigned V_SYNC_LINES  = 3,
  parameter int unsigned V_BACK_LINES  = 10,
  parameter int unsigned V_FRONT_LINES = 2
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic [1:0] i_pattern,
  output logic       o_pclk,
  output logic       o_vsync,
  output logic       o_href,
  output logic [7:0] o_data,
  output logic       o_frame_done
);

  localparam int unsigned LINE_BYTES = 2 * WIDTH + H_BLANK;
  localparam int unsigned MAX_SB     = (V_SYNC_LINES > V_BACK_LINES) ? V_SYNC_LINES : V_BACK_LINES;
  localparam int unsigned MAX_VL     = (MAX_SB > V_FRONT_LINES) ? MAX_SB : V_FRONT_LINES;
  localparam int unsigned BW         = $clog2(LINE_BYTES + 1);
  localparam int unsigned LW         = $clog2(MAX_VL + 1);
  localparam int unsigned XW         = $clog2(WIDTH + 1);
  localparam int unsigned YW         = $clog2(HEIGHT + 1);

  localparam logic [BW-1:0] LINE_LAST   = BW'(LINE_BYTES - 1);
  localparam logic [BW-1:0] ACT_LAST    = BW'(2 * WIDTH - 1);
  localparam logic [BW-1:0] HB_LAST     = BW'(H_BLANK - 1);
  localparam logic [LW-1:0] VSYNC_LAST  = LW'(V_SYNC_LINES - 1);
  localparam logic [LW-1:0] VBACK_LAST  = LW'(V_BACK_LINES - 1);
  localparam logic [LW-1:0] VFRONT_LAST = LW'(V_FRONT_LINES - 1);
  localparam logic [XW-1:0] X_LAST      = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST      = YW'(HEIGHT - 1);

  state_e          r_state;
  pattern_e        r_pattern;
  logic [BW-1:0]   r_byte_cnt;
  logic [LW-1:0]   r_line_cnt;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [7:0]      r_lo;
  logic            r_pclk;
  logic            r_vsync;
  logic            r_href;
  logic [7:0]      r_data;
  logic            r_frame_done;

  logic [15:0]     w_pix;
  logic [XW-1:0]   w_x_inc;
  logic [YW-1:0]   w_y_inc;

  assign w_x_inc = (r_x == X_LAST) ? '0 : r_x + 1'b1;
  assign w_y_inc = (r_y == Y_LAST) ? '0 : r_y + 1'b1;

  pattern_gen #(
    .WIDTH (WIDTH),
    .XW    (XW),
    .YW    (YW)
  ) u_pattern_gen (
    .i_pattern (r_pattern),
    .i_x       (r_x),
    .i_y       (r_y),
    .o_rgb     (w_pix)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_pattern    <= PatBars;
      r_byte_cnt   <= '0;
      r_line_cnt   <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_lo         <= '0;
      r_pclk       <= 1'b0;
      r_vsync      <= 1'b0;
      r_href       <= 1'b0;
      r_data       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_pclk       <= ~r_pclk;
      r_frame_done <= 1'b0;
      // Byte boundary: this edge drives PCLK low.
      if (r_pclk) begin
        unique case (r_state)
          StIdle: begin
            if (i_enable) begin
              r_state    <= StVsync;
              r_vsync    <= 1'b1;
              r_pattern  <= pattern_e'(i_pattern);
              r_byte_cnt <= '0;
              r_line_cnt <= '0;
            end
          end
          StVsync: begin
            if (r_byte_cnt == LINE_LAST) begin
              r_byte_cnt <= '0;
              if (r_line_cnt == VSYNC_LAST) begin
                r_line_cnt <= '0;
                r_state    <= StVback;
                r_vsync    <= 1'b0;
              end else begin
                r_line_cnt <= r_line_cnt + 1'b1;
              end
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
            end
          end
          StVback: begin
            if (r_byte_cnt == LINE_LAST) begin
              r_byte_cnt <= '0;
              if (r_line_cnt == VBACK_LAST) begin
                r_line_cnt <= '0;
                r_state    <= StActive;
                r_href     <= 1'b1;
                r_data     <= w_pix[15:8];
                r_lo       <= w_pix[7:0];
                r_x        <= w_x_inc;
              end else begin
                r_line_cnt <= r_line_cnt + 1'b1;
              end
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
            end
          end
          StActive: begin
            if (r_byte_cnt == ACT_LAST) begin
              r_byte_cnt <= '0;
              r_state    <= StHblank;
              r_href     <= 1'b0;
              r_data     <= '0;
              r_y        <= w_y_inc;
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
              // x already advanced when the high byte went out.
              if (!r_byte_cnt[0]) begin
                r_data <= r_lo;
              end else begin
                r_data <= w_pix[15:8];
                r_lo   <= w_pix[7:0];
                r_x    <= w_x_inc;
              end
            end
          end
          StHblank: begin
            if (r_byte_cnt == HB_LAST) begin
              r_byte_cnt <= '0;
              // y wrapped to 0 at the end of the last active line.
              if (r_y == '0) begin
                r_state <= StVfront;
              end else begin
                r_state <= StActive;
                r_href  <= 1'b1;
                r_data  <= w_pix[15:8];
                r_lo    <= w_pix[7:0];
                r_x     <= w_x_inc;
              end
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
            end
          end
          StVfront: begin
            if (r_byte_cnt == LINE_LAST) begin
              r_byte_cnt <= '0;
              if (r_line_cnt == VFRONT_LAST) begin
                r_line_cnt   <= '0;
                r_frame_done <= 1'b1;
                if (i_enable) begin
                  r_state   <= StVsync;
                  r_vsync   <= 1'b1;
                  r_pattern <= pattern_e'(i_pattern);
                end else begin
                  r_state <= StIdle;
                end
              end else begin
                r_line_cnt <= r_line_cnt + 1'b1;
              end
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign o_pclk       = r_pclk;
  assign o_vsync      = r_vsync;
  assign o_href       = r_href;
  assign o_data       = r_data;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_camera_pattern_tx.sv
// Scoreboard bench for camera_pattern_tx with reduced frame geometry.
module tb_camera_pattern_tx;

  localparam int TW  = 40;
  localparam int TH  = 20;
  localparam int THB = 6;
  localparam int TVS = 2;
  localparam int TVB = 3;
  localparam int TVF = 1;
  localparam int LINE_CLK  = 2 * (2 * TW + THB);
  localparam int FRAME_CLK = (TVS + TVB + TH + TVF) * LINE_CLK;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] pattern = 2'd0;
  logic       pclk, vsync, href, frame_done;
  logic [7:0] data;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int fd_cnt = 0;
  int href_cnt = 0;
  int line_bytes = 0;
  logic prev_href = 1'b0;
  logic [7:0] exp_q[$];

  camera_pattern_tx #(
    .WIDTH         (TW),
    .HEIGHT        (TH),
    .H_BLANK       (THB),
    .V_SYNC_LINES  (TVS),
    .V_BACK_LINES  (TVB),
    .V_FRONT_LINES (TVF)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_enable     (enable),
    .i_pattern    (pattern),
    .o_pclk       (pclk),
    .o_vsync      (vsync),
    .o_href       (href),
    .o_data       (data),
    .o_frame_done (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic logic [15:0] ref_pixel(input int p, input int x, input int y);
    logic [15:0] bars [8];
    bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    case (p)
      1: return 16'hF800;
      2: return 16'h07E0;
      3: return ((((x / 16) + (y / 16)) % 2) == 1) ? 16'hFFFF : 16'h0000;
      default: return bars[(x * 8) / TW];
    endcase
  endfunction

  task automatic push_frame(input int p);
    logic [15:0] px;
    for (int y = 0; y < TH; y++) begin
      for (int x = 0; x < TW; x++) begin
        px = ref_pixel(p, x, y);
        exp_q.push_back(px[15:8]);
        exp_q.push_back(px[7:0]);
      end
    end
  endtask

  // sel: 0 vsync, 1 href, 2 frame_done. Returns the cycle it was seen, or -1.
  task automatic wait_for(input int sel, input logic val, input int budget, output int at);
    logic s;
    int   i;
    at = -1;
    i = 0;
    while (at < 0 && i < budget) begin
      @(negedge clk);
      case (sel)
        0:       s = vsync;
        1:       s = href;
        default: s = frame_done;
      endcase
      if (s == val) at = cyc;
      i++;
    end
    if (at < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_sel%0d: got no level %0b in %0d cycles, expected it", sel, val, budget);
    end
  endtask

  task automatic check_idle(input string tag);
    repeat (20) @(negedge clk);
    check({tag, "_vsync_idle"}, int'(vsync), 0);
    check({tag, "_href_idle"}, int'(href), 0);
    check({tag, "_data_idle"}, int'(data), 0);
  endtask

  // Monitor: pops one expected byte per HREF-high byte period.
  always @(negedge clk) begin
    if (rst) begin
      line_bytes = 0;
      href_cnt   = 0;
      prev_href  = 1'b0;
    end else begin
      if (href && !prev_href) begin
        href_cnt++;
        line_bytes = 0;
      end
      if (!href && prev_href) check("bytes_per_line", line_bytes, 2 * TW);
      if (pclk) begin
        if (href) begin
          line_bytes++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_byte: got %0d, expected no byte", data);
          end else begin
            check("data_byte", int'(data), int'(exp_q.pop_front()));
          end
        end else begin
          check("data_zero_when_href_low", int'(data), 0);
        end
      end
      if (frame_done) begin
        check("href_pulses_per_frame", href_cnt, TH);
        href_cnt = 0;
        fd_cnt++;
      end
      prev_href = href;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no end of test, expected one");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, c0, c1, c2, c3, c4, c5, c6, p, fd_before;

    // Reset state
    repeat (4) @(negedge clk);
    check("rst_pclk", int'(pclk), 0);
    check("rst_vsync", int'(vsync), 0);
    check("rst_href", int'(href), 0);
    check("rst_data", int'(data), 0);
    check("rst_frame_done", int'(frame_done), 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("idle_no_vsync_without_enable", int'(vsync), 0);

    // Single frames; ENABLE dropped early, PATTERN scrambled after latching
    for (int k = 0; k < 6; k++) begin
      p = (k < 4) ? k : int'($urandom_range(0, 3));
      @(negedge clk);
      pattern = 2'(p);
      enable  = 1'b1;
      push_frame(p);
      c0 = cyc;
      wait_for(0, 1'b1, 10, c);
      check("vsync_latency_ok", int'(c >= c0 + 1 && c <= c0 + 2), 1);
      repeat (3) @(negedge clk);
      enable  = 1'b0;
      pattern = 2'($urandom_range(0, 3));
      wait_for(2, 1'b1, FRAME_CLK + 50, c);
      check_idle("single");
    end

    // Continuous frames and timing
    p = int'($urandom_range(0, 3));
    @(negedge clk);
    pattern = 2'(p);
    enable  = 1'b1;
    repeat (3) push_frame(p);
    wait_for(0, 1'b1, 10, c0);
    wait_for(0, 1'b0, FRAME_CLK, c1);
    check("vsync_high_clocks", c1 - c0, TVS * LINE_CLK);
    wait_for(1, 1'b1, FRAME_CLK, c2);
    wait_for(1, 1'b0, LINE_CLK, c);
    wait_for(1, 1'b1, LINE_CLK, c3);
    check("line_period_clocks", c3 - c2, LINE_CLK);
    wait_for(2, 1'b1, FRAME_CLK, c4);
    @(negedge clk);
    check("frame_done_one_cycle", int'(frame_done), 0);
    wait_for(2, 1'b1, FRAME_CLK + 50, c5);
    check("frame_done_period", c5 - c4, FRAME_CLK);
    check("back_to_back_vsync", int'(vsync), 1);
    enable  = 1'b0;
    pattern = 2'($urandom_range(0, 3));
    wait_for(2, 1'b1, FRAME_CLK + 50, c6);
    check("last_frame_period", c6 - c5, FRAME_CLK);
    check_idle("cont");

    // Reset in the middle of an active line
    @(negedge clk);
    pattern = 2'd2;
    enable  = 1'b1;
    push_frame(2);
    wait_for(1, 1'b1, FRAME_CLK, c);
    repeat (7) @(negedge clk);
    check("pre_reset_href", int'(href), 1);
    fd_before = fd_cnt;
    #2 rst = 1'b1;
    #1;
    check("async_rst_pclk", int'(pclk), 0);
    check("async_rst_vsync", int'(vsync), 0);
    check("async_rst_href", int'(href), 0);
    check("async_rst_data", int'(data), 0);
    check("async_rst_frame_done", int'(frame_done), 0);
    exp_q.delete();
    repeat (5) @(negedge clk);
    pattern = 2'd3;
    push_frame(3);
    rst = 1'b0;
    c0 = cyc;
    wait_for(0, 1'b1, 10, c);
    check("post_reset_vsync_latency_ok", int'(c >= c0 + 1 && c <= c0 + 2), 1);
    check("no_frame_done_on_abort", fd_cnt, fd_before);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    wait_for(2, 1'b1, FRAME_CLK + 50, c);
    check_idle("post_reset");

    check("frame_done_total", fd_cnt, 10);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
